// File: rtl/hallway_pkg.sv
// Shared hallway types: screen geometry, row/column types and the
// sequencer state encoding used by the generator, drawer and collision logic.
package hallway_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef logic [6:0] row_t;
   typedef logic [7:0] col_t;

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      START,
      ARM,
      WAIT,
      ADVANCE
   } state_t;

endpackage

// File: rtl/hallway_lfsr.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Ports: clock, reset (async high), advance (step once), value (state).
module hallway_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       advance,
   output logic [7:0] value
);

   // An all-zero state would lock up, so a zero seed becomes 1.
   localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [7:0] TAPS = 8'hB8;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         value <= INIT;
      else if (advance)
         value <= {1'b0, value[7:1]} ^ (value[0] ? TAPS : 8'h00);
   end

endmodule

// File: rtl/hallway_path_generator.sv
// Hallway column sequencer: random-walk walls with a shrinking gap,
// drawer handshake and wrapping scroll column.
// Ports: clock, reset (async high), enable, tick, drawer_done in;
// start, column, upper_pos, lower_pos, busy, columns_generated out.
module hallway_path_generator
   import hallway_pkg::*;
#(
   parameter int         INIT_UPPER   = 30,
   parameter int         INIT_GAP     = 60,
   parameter int         GAP_MIN      = 24,
   parameter int         SHRINK_EVERY = 32,
   parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        tick,
   input  logic        drawer_done,
   output logic        start,
   output col_t        column,
   output row_t        upper_pos,
   output row_t        lower_pos,
   output logic        busy,
   output logic [15:0] columns_generated
);

   localparam row_t        UP0   = row_t'(INIT_UPPER);
   localparam row_t        GAP0  = row_t'(INIT_GAP);
   localparam row_t        GMIN  = row_t'(GAP_MIN);
   localparam logic [7:0]  HMAX  = 8'(SCREEN_H - 1);
   localparam col_t        WMAX  = col_t'(SCREEN_W - 1);
   localparam logic [15:0] SLAST = 16'(SHRINK_EVERY - 1);

   if (INIT_UPPER + INIT_GAP > SCREEN_H - 1) begin : g_bad_walls
      $error("INIT_UPPER + INIT_GAP must not exceed SCREEN_H-1");
   end
   if (SHRINK_EVERY < 1) begin : g_bad_shrink
      $error("SHRINK_EVERY must be at least 1");
   end

   state_t      state;
   state_t      state_nx;
   row_t        gap;
   row_t        gap_nx;
   row_t        upper_nx;
   row_t        lower_nx;
   logic [7:0]  down_sum;
   logic [15:0] shrink_cnt;
   logic        shrink_pend;
   logic        lfsr_adv;
   logic [7:0]  lfsr;

   // Stepped on entry to STEP so the fresh value is already
   // registered while STEP decides the wall move.
   assign lfsr_adv = (state == IDLE) && tick && enable;

   hallway_lfsr #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clock  (clock),
      .reset  (reset),
      .advance(lfsr_adv),
      .value  (lfsr)
   );

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            if (tick && enable)
               state_nx = STEP;
         end
         STEP: begin
            busy     = 1'b1;
            state_nx = START;
         end
         START: begin
            busy     = 1'b1;
            start    = 1'b1;
            state_nx = ARM;
         end
         ARM: begin
            busy = 1'b1;
            if (!drawer_done)
               state_nx = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (drawer_done)
               state_nx = ADVANCE;
         end
         ADVANCE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Shrink first, then clamp the walk against the shrunk gap.
   always_comb begin
      gap_nx = gap;
      if (shrink_pend && (gap > GMIN))
         gap_nx = gap - 7'd1;
      down_sum = {1'b0, upper_pos} + {1'b0, gap_nx} + 8'd1;
      upper_nx = upper_pos;
      case (lfsr[1:0])
         2'b00: if (upper_pos != 7'd0) upper_nx = upper_pos - 7'd1;
         2'b11: if (down_sum <= HMAX) upper_nx = upper_pos + 7'd1;
         default: upper_nx = upper_pos;
      endcase
      lower_nx = upper_nx + gap_nx;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         column            <= '0;
         upper_pos         <= UP0;
         lower_pos         <= UP0 + GAP0;
         gap               <= GAP0;
         shrink_cnt        <= '0;
         shrink_pend       <= 1'b0;
         columns_generated <= '0;
      end else begin
         state <= state_nx;
         if (state == STEP) begin
            gap         <= gap_nx;
            upper_pos   <= upper_nx;
            lower_pos   <= lower_nx;
            shrink_pend <= 1'b0;
         end
         if (state == ADVANCE) begin
            column <= (column == WMAX) ? '0 : column + 8'd1;
            if (columns_generated != 16'hFFFF)
               columns_generated <= columns_generated + 16'd1;
            if (shrink_cnt == SLAST) begin
               shrink_cnt  <= '0;
               shrink_pend <= 1'b1;
            end else begin
               shrink_cnt <= shrink_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hallway_path_generator.sv
// Scoreboard bench: three generator configurations, a drawer model per
// instance, and a reference walk model producing expected columns.
module tb_hallway_path_generator;

   localparam int N = 3;

   typedef struct packed {
      logic [7:0] col;
      logic [6:0] up;
      logic [6:0] lo;
   } exp_t;

   logic        clk;
   logic        rst     [N];
   logic        en      [N];
   logic        tick    [N];
   logic        done    [N];
   logic        start_o [N];
   logic [7:0]  col_o   [N];
   logic [6:0]  up_o    [N];
   logic [6:0]  lo_o    [N];
   logic        busy_o  [N];
   logic [15:0] gen_o   [N];

   int         draw_len [N];
   int         dcnt     [N];
   int         m_up     [N];
   int         m_cnt    [N];
   logic [7:0] m_lfsr   [N];
   exp_t       q        [N][$];

   int nchk  = 0;
   int npass = 0;

   for (genvar g = 0; g < N; g++) begin : g_dut
      hallway_path_generator #(
         .INIT_UPPER  (g == 2 ? 2 : 30),
         .INIT_GAP    (60),
         .GAP_MIN     (g == 1 ? 58 : 24),
         .SHRINK_EVERY(g == 1 ? 4 : 32),
         .LFSR_SEED   (g == 2 ? 8'h80 : 8'hA5)
      ) dut (
         .clock            (clk),
         .reset            (rst[g]),
         .enable           (en[g]),
         .tick             (tick[g]),
         .drawer_done      (done[g]),
         .start            (start_o[g]),
         .column           (col_o[g]),
         .upper_pos        (up_o[g]),
         .lower_pos        (lo_o[g]),
         .busy             (busy_o[g]),
         .columns_generated(gen_o[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drawer: registered done drops after start, rises draw_len cycles later.
   always @(posedge clk) begin
      for (int g = 0; g < N; g++) begin
         if (rst[g]) begin
            done[g] <= 1'b1;
            dcnt[g] <= 0;
         end else if (start_o[g]) begin
            done[g] <= 1'b0;
            dcnt[g] <= draw_len[g];
         end else if (!done[g]) begin
            if (dcnt[g] <= 1) done[g] <= 1'b1;
            else dcnt[g] <= dcnt[g] - 1;
         end
      end
   end

   function automatic int p_up(input int g);
      return (g == 2) ? 2 : 30;
   endfunction
   function automatic int p_gmin(input int g);
      return (g == 1) ? 58 : 24;
   endfunction
   function automatic int p_se(input int g);
      return (g == 1) ? 4 : 32;
   endfunction
   function automatic logic [7:0] p_seed(input int g);
      return (g == 2) ? 8'h80 : 8'hA5;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   task automatic model_reset(input int g);
      m_up[g]   = p_up(g);
      m_lfsr[g] = p_seed(g);
      m_cnt[g]  = 0;
      q[g].delete();
   endtask

   // Column k uses gap = max(GAP_MIN, 60 - k/SHRINK_EVERY); walls walk
   // by the low LFSR bits and refuse moves that leave the screen.
   task automatic model_push(input int g);
      int         k;
      int         gp;
      int         cand;
      logic [7:0] l;
      exp_t       e;
      k  = m_cnt[g];
      gp = 60 - k / p_se(g);
      if (gp < p_gmin(g)) gp = p_gmin(g);
      l = m_lfsr[g];
      l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
      m_lfsr[g] = l;
      cand = m_up[g];
      if (l[1:0] == 2'b00) cand = cand - 1;
      else if (l[1:0] == 2'b11) cand = cand + 1;
      if (cand >= 0 && cand + gp <= 119) m_up[g] = cand;
      e.col = 8'(k % 160);
      e.up  = 7'(m_up[g]);
      e.lo  = 7'(m_up[g] + gp);
      q[g].push_back(e);
      m_cnt[g] = m_cnt[g] + 1;
   endtask

   task automatic chk_reset(input int g);
      chk("reset column", col_o[g], 0);
      chk("reset upper", up_o[g], p_up(g));
      chk("reset lower", lo_o[g], p_up(g) + 60);
      chk("reset start", start_o[g], 0);
      chk("reset busy", busy_o[g], 0);
      chk("reset count", gen_o[g], 0);
   endtask

   task automatic run_col(input int g, input bit inj);
      int col;
      bit ok;
      @(negedge clk);
      col = m_cnt[g] % 160;
      model_push(g);
      tick[g] = 1'b1;
      @(negedge clk);
      tick[g] = 1'b0;
      chk("step busy", busy_o[g], 1);
      chk("start early", start_o[g], 0);
      @(negedge clk);
      chk("start pulse", start_o[g], 1);
      @(negedge clk);
      chk("start width", start_o[g], 0);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         tick[g] = 1'b0;
         if (int'(gen_o[g]) == m_cnt[g]) begin
            ok = 1'b1;
         end else begin
            if (busy_o[g]) chk("column stable", col_o[g], col);
            if (inj && busy_o[g] && $urandom_range(0, 7) == 0)
               tick[g] = 1'b1;
         end
      end
      tick[g] = 1'b0;
      chk("column completion", ok, 1);
      chk("count", gen_o[g], m_cnt[g]);
      chk("column advanced", col_o[g], m_cnt[g] % 160);
   endtask

   initial begin
      for (int g = 0; g < N; g++) begin
         rst[g]      = 1'b1;
         en[g]       = 1'b0;
         tick[g]     = 1'b0;
         draw_len[g] = 3;
         model_reset(g);
      end

      fork
         forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
               if (!rst[g] && start_o[g]) begin
                  if (q[g].size() == 0) begin
                     chk("unexpected start", 1, 0);
                  end else begin
                     exp_t e;
                     e = q[g].pop_front();
                     chk("start column", col_o[g], e.col);
                     chk("start upper", up_o[g], e.up);
                     chk("start lower", lo_o[g], e.lo);
                     chk("lower in screen", int'(lo_o[g] <= 7'd119), 1);
                  end
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      for (int g = 0; g < N; g++) chk_reset(g);
      for (int g = 0; g < N; g++) rst[g] = 1'b0;
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
         chk_reset(g);
         en[g] = 1'b1;
      end

      // long draw on a single column
      draw_len[0] = 120;
      run_col(0, 1'b0);

      // full screen with wrap, random draw lengths and dropped ticks
      for (int i = 0; i < 160; i++) begin
         draw_len[0] = $urandom_range(1, 4);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_col(0, 1'b1);
      end
      chk("wrapped column", col_o[0], 1);

      // ticks ignored while disabled
      en[0] = 1'b0;
      @(negedge clk);
      tick[0] = 1'b1;
      @(negedge clk);
      tick[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("disabled busy", busy_o[0], 0);
      chk("disabled count", gen_o[0], 161);
      en[0] = 1'b1;

      // extra tick during WAIT, then reset in the middle of the draw
      draw_len[0] = 40;
      @(negedge clk);
      model_push(0);
      tick[0] = 1'b1;
      @(negedge clk);
      tick[0] = 1'b0;
      repeat (10) @(negedge clk);
      tick[0] = 1'b1;
      @(negedge clk);
      tick[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid-wait busy", busy_o[0], 1);
      rst[0] = 1'b1;
      #1;
      chk("reset start now", start_o[0], 0);
      chk("reset busy now", busy_o[0], 0);
      chk("reset column now", col_o[0], 0);
      model_reset(0);
      @(negedge clk);
      rst[0] = 1'b0;
      @(negedge clk);
      chk_reset(0);
      for (int i = 0; i < 3; i++) begin
         draw_len[0] = $urandom_range(1, 5);
         run_col(0, 1'b1);
      end

      // fast gap shrink down to its floor
      for (int i = 0; i < 12; i++) begin
         draw_len[1] = $urandom_range(1, 3);
         run_col(1, 1'b1);
      end
      chk("shrunk gap", int'(lo_o[1]) - int'(up_o[1]), 58);

      // upward walk pinned at the top row
      for (int i = 0; i < 6; i++) begin
         draw_len[2] = 2;
         run_col(2, 1'b0);
      end
      chk("top clamp", up_o[2], 0);

      for (int g = 0; g < N; g++)
         chk("scoreboard drained", q[g].size(), 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
